bt_encoder: RTL

Packet serializer for the host link: the counterpart of the Bluetooth command decoder. Takes {command, x, y} packets from the drawing core, such as cursor echo or colour-pick reports. Queues them in a small FIFO and emits each as a 3-byte (optionally 4-byte) framed stream toward the UART transmitter. Sits between the paint control logic and `uart_tx`, one byte per valid/ready handshake.

---
 rtl/bt_proto_pkg.sv | 40 ++++
 rtl/bt_pkt_fifo.sv | 63 ++++++
 rtl/bt_encoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bt_proto_pkg.sv
// Shared framing constants, state encodings and byte builders for the host-link
// encoder and decoder.
package bt_proto_pkg;

    localparam logic [1:0] HDR_PREFIX  = 2'b11;
    localparam logic [1:0] DATA_PREFIX = 2'b00;
    localparam logic [1:0] CHK_PREFIX  = 2'b10;

    localparam logic [2:0] CMD_MOVE = 3'd1;
    localparam logic [2:0] CMD_DRAW = 3'd2;
    localparam logic [2:0] CMD_PICK = 3'd3;

    localparam int unsigned PKT_W = 15;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_X    = 3'd2;
    localparam logic [2:0] S_Y    = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    typedef struct packed {
        logic [2:0] cmd;
        logic [5:0] x;
        logic [5:0] y;
    } bt_pkt_t;

    function automatic logic [7:0] hdr_byte(input logic [2:0] cmd);
        return {HDR_PREFIX, 3'b000, cmd};
    endfunction

    function automatic logic [7:0] data_byte(input logic [5:0] v);
        return {DATA_PREFIX, v};
    endfunction

    // Checksum prefix 10 is skipped by older decoders waiting for a header.
    function automatic logic [7:0] chk_byte(input bt_pkt_t p);
        return {CHK_PREFIX, {3'b000, p.cmd} ^ p.x ^ p.y};
    endfunction

endpackage

// File: rtl/bt_pkt_fifo.sv
// Synchronous packet FIFO with registered occupancy count; full/empty derive from
// the count only, so a push into a full FIFO is refused even alongside a pop.
module bt_pkt_fifo #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/bt_encoder.sv
// Host-link packet serializer: queues {cmd, x, y} packets and streams framed bytes
// to the UART. Define BT_ENC_CHECKSUM_EN to append a fourth checksum byte per frame.
module bt_encoder
    import bt_proto_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] command_id,
    input  logic [5:0] x_in,
    input  logic [5:0] y_in,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       busy
);

    logic [2:0]       r_state;
    bt_pkt_t          r_pkt;
    logic             r_tx_valid;
    logic [7:0]       r_tx_byte;

    logic [2:0]       w_state_d;
    bt_pkt_t          w_pkt_d;
    logic             w_tx_valid_d;
    logic [7:0]       w_tx_byte_d;
    logic             w_accept;
    logic             w_last;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [PKT_W-1:0] w_rdata;
    bt_pkt_t          w_fifo_pkt;

    bt_pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_valid),
        .i_wdata ({command_id, x_in, y_in}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_fifo_pkt = w_rdata;
    assign w_accept   = r_tx_valid & tx_ready;

    always_comb begin
        w_state_d    = r_state;
        w_pkt_d      = r_pkt;
        w_tx_valid_d = r_tx_valid;
        w_tx_byte_d  = r_tx_byte;
        w_pop        = 1'b0;
        w_last       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_pkt_d      = w_fifo_pkt;
                    w_tx_byte_d  = hdr_byte(w_fifo_pkt.cmd);
                    w_tx_valid_d = 1'b1;
                    w_state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (w_accept) begin
                    w_tx_byte_d = data_byte(r_pkt.x);
                    w_state_d   = S_X;
                end
            end
            S_X: begin
                if (w_accept) begin
                    w_tx_byte_d = data_byte(r_pkt.y);
                    w_state_d   = S_Y;
                end
            end
            S_Y: begin
                if (w_accept) begin
`ifdef BT_ENC_CHECKSUM_EN
                    w_tx_byte_d = chk_byte(r_pkt);
                    w_state_d   = S_CHK;
`else
                    w_last      = 1'b1;
`endif
                end
            end
`ifdef BT_ENC_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) begin
                    w_last = 1'b1;
                end
            end
`endif
            default: begin
                w_state_d    = S_IDLE;
                w_tx_valid_d = 1'b0;
            end
        endcase

        // Final byte taken: chain straight into the next header when one is queued.
        if (w_last) begin
            if (!w_empty) begin
                w_pop       = 1'b1;
                w_pkt_d     = w_fifo_pkt;
                w_tx_byte_d = hdr_byte(w_fifo_pkt.cmd);
                w_state_d   = S_HDR;
            end else begin
                w_tx_valid_d = 1'b0;
                w_state_d    = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pkt      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            r_state    <= w_state_d;
            r_pkt      <= w_pkt_d;
            r_tx_valid <= w_tx_valid_d;
            r_tx_byte  <= w_tx_byte_d;
        end
    end

    assign cmd_ready = ~w_full;
    assign tx_valid  = r_tx_valid;
    assign tx_byte   = r_tx_byte;
    assign busy      = (r_state != S_IDLE) | ~w_empty;

endmodule
